seg_scan_driver: RTL and testbench

- Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits. It is the scanning, multi-digit generalisation of the single-digit hex-to-segment decoder.
- Accepts a packed hex word with per-digit decimal-point and enable masks, and latches them through a load strobe. Updates take effect only at frame boundaries, so a digit is never shown half-updated.
- Sits between the lab datapath (counters, random-number or ALU results) and the board's shared segment/anode pins.

---
 rtl/seg_pkg.sv | 50 +++++
 rtl/seg_scan_driver_if.sv | 37 +++
 rtl/seg_hex_decode.sv | 20 ++
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants and the hex-to-7-segment encoding for the
//                segment display drivers.
//                  SEG_BLANK        - all segments off (active-low pins)
//                  SEG_A .. SEG_DP  - bit positions in the 8-bit segment bus
//                  hex2seg()        - nibble -> active-high {a,b,c,d,e,f,g}
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit positions within the 8-bit segment bus
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-high pattern, MSB = a, LSB = g. Every code is defined.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0:    segs = 7'h7E;
            4'h1:    segs = 7'h30;
            4'h2:    segs = 7'h6D;
            4'h3:    segs = 7'h79;
            4'h4:    segs = 7'h33;
            4'h5:    segs = 7'h5B;
            4'h6:    segs = 7'h5F;
            4'h7:    segs = 7'h70;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h7B;
            4'hA:    segs = 7'h77;
            4'hB:    segs = 7'h1F;
            4'hC:    segs = 7'h4E;
            4'hD:    segs = 7'h3D;
            4'hE:    segs = 7'h4F;
            default: segs = 7'h47;
        endcase
        return segs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_if
//  Description : Bundle between the datapath (master) and the scanning
//                display driver (slave).
//                  load        - 1-cycle strobe capturing value/dp/en
//                  value       - packed hex nibbles, nibble i = digit i
//                  dp / en     - per-digit decimal point / enable
//                  seg_n       - active-low segments {a..g,dp}
//                  an_n        - active-low anode selects
//                  frame_start - pulse when digit 0 starts a new frame
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     en;
    logic [7:0]                seg_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_start;

    modport master (
        output load, value, dp, en,
        input  seg_n, an_n, frame_start
    );

    modport slave (
        input  load, value, dp, en,
        output seg_n, an_n, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_decode
//  Description : Combinational nibble to 7-segment decoder (active-high a..g).
//                Also usable by the single-digit static drivers.
//                  i_nibble - hex code 0..F
//                  o_seg    - {a,b,c,d,e,f,g}, 1 = segment lit
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output wire logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for NUM_DIGITS common-anode 7-seg
//                digits. Loaded data sits in pending registers and is moved
//                to the displayed (active) set only at a frame boundary.
//                  clk, rst - clock, synchronous active-high reset
//                  bus      - seg_scan_driver_if slave: load/value/dp/en in,
//                             seg_n/an_n/frame_start out (all registered)
//                Optional build macro SEG_LZ_SUPPRESS_EN adds leading-zero
//                blanking of the active data.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int CNT_W      = $clog2(SCAN_DIV),
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input wire logic          clk,
    input wire logic          rst,
    seg_scan_driver_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_pend_value;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic [NUM_DIGITS-1:0]     r_pend_en;
    logic [4*NUM_DIGITS-1:0]   r_act_value;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [NUM_DIGITS-1:0]     r_act_en;
    logic [7:0]                r_seg_n;
    logic [NUM_DIGITS-1:0]     r_an_n;
    logic                      r_frame_start;

    logic                      w_tick;
    logic                      w_commit;
    logic [3:0]                w_nib;
    logic                      w_dp_cur;
    logic                      w_en_cur;
    logic [NUM_DIGITS-1:0]     w_an_sel;
    logic [6:0]                w_hex;
    logic                      w_lit;
    logic [7:0]                w_seg_next;
    logic [NUM_DIGITS-1:0]     w_an_next;

    assign w_tick   = (r_cnt == c_cnt_last);
    assign w_commit = w_tick && (r_idx == c_idx_last);

    // Select the active data of the digit currently being scanned; the
    // anode select is the active-low one-hot of the same index.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_cur = 1'b0;
        w_en_cur = 1'b0;
        w_an_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_act_value[4*i +: 4];
                w_dp_cur    = r_act_dp[i];
                w_en_cur    = r_act_en[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .i_nibble (w_nib),
        .o_seg    (w_hex)
    );

`ifdef SEG_LZ_SUPPRESS_EN
    // Walk from the most significant digit down: a digit is suppressed while
    // every enabled digit above it holds zero, its own nibble is zero and it
    // carries no decimal point. Digit 0 always stays visible.
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic                  w_higher_zero;

    always_comb begin
        w_lz_mask     = '0;
        w_higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_mask[i] = w_higher_zero && (r_act_value[4*i +: 4] == 4'h0) && !r_act_dp[i];
            if (r_act_en[i] && (r_act_value[4*i +: 4] != 4'h0)) begin
                w_higher_zero = 1'b0;
            end
        end
    end

    // ~w_an_sel is the one-hot of the scanned digit
    assign w_lit = w_en_cur && !(|(w_lz_mask & ~w_an_sel));
`else
    assign w_lit = w_en_cur;
`endif

    // Anodes go dark in the tick cycle while the segments keep their pattern,
    // so the digit is off before the segment bus changes to the next digit.
    assign w_seg_next = w_lit ? ~{w_hex, w_dp_cur} : SEG_BLANK;
    assign w_an_next  = (w_lit && !w_tick) ? w_an_sel : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pend_value  <= '0;
            r_pend_dp     <= '0;
            r_pend_en     <= '0;
            r_act_value   <= '0;
            r_act_dp      <= '0;
            r_act_en      <= '0;
            r_seg_n       <= SEG_BLANK;
            r_an_n        <= '1;
            r_frame_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (bus.load) begin
                r_pend_value <= bus.value;
                r_pend_dp    <= bus.dp;
                r_pend_en    <= bus.en;
            end

            // A load landing on the commit cycle bypasses the pending set so
            // the freshest data is what the next frame shows.
            if (w_commit) begin
                if (bus.load) begin
                    r_act_value <= bus.value;
                    r_act_dp    <= bus.dp;
                    r_act_en    <= bus.en;
                end else begin
                    r_act_value <= r_pend_value;
                    r_act_dp    <= r_pend_dp;
                    r_act_en    <= r_pend_en;
                end
            end

            r_frame_start <= w_commit;
            r_seg_n       <= w_seg_next;
            r_an_n        <= w_an_next;
        end
    end

    assign bus.seg_n       = r_seg_n;
    assign bus.an_n        = r_an_n;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (4 digits, dwell 4).
//                A time-based reference model predicts seg_n/an_n/frame_start
//                every cycle; directed frames are also checked against
//                hand-derived segment patterns. Honours SEG_LZ_SUPPRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int FRAME = N * SD;
`ifdef SEG_LZ_SUPPRESS_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic lz_blank(input int d, input logic [15:0] v, input logic [3:0] e, input logic [3:0] p);
        logic hi_zero;
        hi_zero = 1'b1;
        for (int j = d + 1; j < N; j++)
            if (e[j] && (v[4*j +: 4] != 4'h0)) hi_zero = 1'b0;
        return LZ_ON && (d != 0) && hi_zero && (v[4*d +: 4] == 4'h0) && !p[d];
    endfunction

    function automatic logic [7:0] f_seg(input int d, input logic [15:0] v, input logic [3:0] e, input logic [3:0] p);
        if (!e[d] || lz_blank(d, v, e, p)) return 8'hFF;
        return ~{ref_hex(v[4*d +: 4]), p[d]};
    endfunction

    function automatic logic [3:0] f_an(input int d, input int ph, input logic [15:0] v, input logic [3:0] e, input logic [3:0] p);
        if (!e[d] || lz_blank(d, v, e, p) || ph == SD - 1) return 4'hF;
        return ~(4'(1) << d);
    endfunction

    int          m_t;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_pe, m_ad, m_ae;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fs;
    bit          started = 1'b0;

    // m_t counts cycles since reset; the display shows what the state of the
    // previous cycle dictates.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_t <= 0;
            m_pv <= '0; m_pd <= '0; m_pe <= '0;
            m_av <= '0; m_ad <= '0; m_ae <= '0;
            exp_seg <= 8'hFF; exp_an <= 4'hF; exp_fs <= 1'b0;
        end else begin
            if (bus.load) begin
                m_pv <= bus.value; m_pd <= bus.dp; m_pe <= bus.en;
            end
            if (m_t % FRAME == FRAME - 1) begin
                if (bus.load) begin
                    m_av <= bus.value; m_ad <= bus.dp; m_ae <= bus.en;
                end else begin
                    m_av <= m_pv; m_ad <= m_pd; m_ae <= m_pe;
                end
            end
            exp_fs  <= (m_t % FRAME == FRAME - 1);
            exp_seg <= f_seg((m_t / SD) % N, m_av, m_ae, m_ad);
            exp_an  <= f_an((m_t / SD) % N, m_t % SD, m_av, m_ae, m_ad);
            m_t     <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_seg", {24'h0, bus.seg_n}, {24'h0, exp_seg});
            check("model_an", {28'h0, bus.an_n}, {28'h0, exp_an});
            check("model_fs", {31'h0, bus.frame_start}, {31'h0, exp_fs});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        bus.load = 1'b1; bus.value = v; bus.dp = d; bus.en = e;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 100);
        check(name, {31'h0, bus.frame_start}, 32'h1);
    endtask

    // Called at the negedge where frame_start is high; returns at the
    // negedge one frame later. s = {d3,d2,d1,d0} seg_n, a = {d3..d0} an_n.
    task automatic check_frame(input string tag, input logic [31:0] s, input logic [15:0] a,
                               input bit mid, input logic [15:0] mid_v);
        for (int d = 0; d < N; d++) begin
            @(negedge clk);
            check({tag, "_seg"}, {24'h0, bus.seg_n}, {24'h0, s[8*d +: 8]});
            check({tag, "_an"}, {28'h0, bus.an_n}, {28'h0, a[4*d +: 4]});
            if (d == 0 && mid) begin
                bus.load = 1'b1; bus.value = mid_v; bus.dp = 4'h0; bus.en = 4'hF;
            end
            @(negedge clk);
            bus.load = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check({tag, "_ghost_an"}, {28'h0, bus.an_n}, 32'hF);
            check({tag, "_ghost_seg"}, {24'h0, bus.seg_n}, {24'h0, s[8*d +: 8]});
        end
    endtask

    initial begin
        int  n;
        bit  blank_ok;
        bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.en = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First frame stays blank, frame_start 16 cycles after release
        blank_ok = 1'b1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (bus.seg_n !== 8'hFF || bus.an_n !== 4'hF || bus.frame_start !== 1'b0) blank_ok = 1'b0;
        end
        check("first_frame_blank", {31'h0, blank_ok}, 32'h1);
        @(negedge clk);
        check("first_fs_latency", {31'h0, bus.frame_start}, 32'h1);

        // Scan order 1234, with ABCD loaded mid-frame (must not show yet)
        drive_load(16'h1234, 4'h0, 4'hF);
        wait_fs("fs_1234", n);
        check("fs_1234_n", n, 15);
        check_frame("scan_1234", 32'h9F_25_0D_99, 16'h7BDE, 1'b1, 16'hABCD);
        check("fs_deferred", {31'h0, bus.frame_start}, 32'h1);
        check_frame("scan_abcd", 32'h11_C1_63_85, 16'h7BDE, 1'b0, 16'h0);

        // Load on the commit cycle wins over the older pending value
        drive_load(16'h7777, 4'h0, 4'hF);
        repeat (14) @(negedge clk);
        bus.load = 1'b1; bus.value = 16'h00F0; bus.dp = 4'h0; bus.en = 4'hF;
        @(negedge clk);
        bus.load = 1'b0;
        check("fs_commit_load", {31'h0, bus.frame_start}, 32'h1);
`ifdef SEG_LZ_SUPPRESS_EN
        check_frame("commit_load", 32'hFF_FF_71_03, 16'hFFDE, 1'b0, 16'h0);
`else
        check_frame("commit_load", 32'h03_03_71_03, 16'h7BDE, 1'b0, 16'h0);
`endif

        // Enable / decimal point masks
        drive_load(16'h8888, 4'b0100, 4'b0101);
        wait_fs("fs_endp", n);
        check_frame("en_dp", 32'hFF_00_FF_01, 16'hFBFE, 1'b0, 16'h0);

`ifdef SEG_LZ_SUPPRESS_EN
        drive_load(16'h0050, 4'h0, 4'hF);
        wait_fs("fs_lz1", n);
        check_frame("lz_0050", 32'hFF_FF_49_03, 16'hFFDE, 1'b0, 16'h0);
        drive_load(16'h0000, 4'h0, 4'hF);
        wait_fs("fs_lz2", n);
        check_frame("lz_0000", 32'hFF_FF_FF_03, 16'hFFFE, 1'b0, 16'h0);
`endif

        // Reset mid-frame: blank immediately, frame restarts from digit 0
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_seg", {24'h0, bus.seg_n}, 32'hFF);
        check("midrst_an", {28'h0, bus.an_n}, 32'hF);
        wait_fs("fs_after_midrst", n);
        check("fs_after_midrst_n", n, 16);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
